// File: rtl/mul_result_collector.sv
// Reassembles multi-beat multiplier products (LS chunk first, framed by rdy)
// into a full-width magnitude plus sign. The result is offered on a
// valid/ready handshake from an output register that is independent of the
// collection shift register.
module mul_result_collector #(
  parameter int P_WIDTH  = 4,
  parameter int BEATS    = 2,
  parameter int HAS_SIGN = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [P_WIDTH-1:0]           p,
  input  logic                         s,
  input  logic                         rdy,
  output logic [P_WIDTH*BEATS-1:0]     prod_data,
  output logic                         prod_sign,
  output logic [P_WIDTH*BEATS:0]       prod_signed,
  output logic                         prod_valid,
  input  logic                         prod_ready,
  output logic                         err_short,
  output logic                         overrun,
  input  logic                         clr_overrun
);

  localparam int PW = P_WIDTH * BEATS;
  localparam int SW = PW + 1;
  localparam int CW = $clog2(BEATS + 1);

  // state | meaning
  // IDLE    | no frame in progress; rdy starts a new frame with chunk 0
  // COLLECT | partial frame held; rdy low here aborts the frame
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] count;
  logic [PW-1:0] shreg;
  logic          sign_cap;

  logic [CW-1:0] idx;
  logic [PW-1:0] frame_val;
  logic          frame_sign;
  logic          done;
  logic          load;
  logic          drop;
  logic [SW-1:0] mag_ext;

  // Merge the incoming chunk into the partial frame and detect the last beat.
  // In IDLE the shift register is already zero, so chunk 0 lands on a clean slate.
  always_comb begin
    idx        = (state == IDLE) ? '0 : count;
    frame_val  = shreg;
    for (int i = 0; i < BEATS; i++) begin
      if (idx == CW'(i)) frame_val[i*P_WIDTH +: P_WIDTH] = p;
    end
    frame_sign = (state == IDLE) ? ((HAS_SIGN != 0) ? s : 1'b0) : sign_cap;
    done       = rdy && (idx == CW'(BEATS - 1));
    load       = done && (!prod_valid || prod_ready);
    drop       = done && prod_valid && !prod_ready;
  end

  // Collection FSM: shift register, beat counter, first-beat sign, abort pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      shreg     <= '0;
      sign_cap  <= 1'b0;
      err_short <= 1'b0;
    end else begin
      err_short <= (state == COLLECT) && !rdy;
      if (done) begin
        state <= IDLE;
        count <= '0;
        shreg <= '0;
      end else if (rdy) begin
        state <= COLLECT;
        count <= idx + CW'(1);
        shreg <= frame_val;
        if (state == IDLE) sign_cap <= frame_sign;
      end else begin
        state <= IDLE;
        count <= '0;
        shreg <= '0;
      end
    end
  end

  // Output holding register and handshake; a completed frame that finds the
  // register full and unconsumed is dropped and flagged instead of overwriting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_data  <= '0;
      prod_sign  <= 1'b0;
      prod_valid <= 1'b0;
    end else if (load) begin
      prod_data  <= frame_val;
      prod_sign  <= frame_sign;
      prod_valid <= 1'b1;
    end else if (prod_valid && prod_ready) begin
      prod_valid <= 1'b0;
    end
  end

  // Sticky overrun flag; a new overrun event wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

  // Two's-complement view of the held result; negating zero yields zero.
  always_comb begin
    mag_ext     = {1'b0, prod_data};
    prod_signed = prod_sign ? (~mag_ext + SW'(1)) : mag_ext;
  end

endmodule

// File: tb/tb_mul_result_collector.sv
// Bench for mul_result_collector: vector table, corner-case sequences and a
// randomized run against a frame-level reference model.
module tb_mul_result_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] p;
  logic       s;
  logic       rdy;
  logic [7:0] prod_data;
  logic       prod_sign;
  logic [8:0] prod_signed;
  logic       prod_valid;
  logic       prod_ready;
  logic       err_short;
  logic       overrun;
  logic       clr_overrun;

  int checks   = 0;
  int failures = 0;

  mul_result_collector #(.P_WIDTH(4), .BEATS(2), .HAS_SIGN(1)) dut (
    .clk(clk), .rst(rst), .p(p), .s(s), .rdy(rdy),
    .prod_data(prod_data), .prod_sign(prod_sign), .prod_signed(prod_signed),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .err_short(err_short),
    .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] c0;
    logic [3:0] c1;
    logic       sg;
    logic [7:0] exp_data;
    logic       exp_sign;
    logic [8:0] exp_signed;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] v, input logic sg);
    rdy = 1'b1; p = v; s = sg;
    step();
  endtask

  task automatic idle();
    rdy = 1'b0; p = 4'($urandom); s = 1'($urandom);
  endtask

  // reference model state
  logic [3:0] m_q[$];
  logic       m_fsign;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_sign;
  logic       m_over;
  logic       m_err;

  function automatic logic [8:0] signed_of(input logic sg, input logic [7:0] mag);
    int v;
    v = sg ? (512 - int'(mag)) % 512 : int'(mag);
    return 9'(v);
  endfunction

  // advance the model by one clock edge using the inputs presented before it
  task automatic model_edge();
    bit complete = 0;
    int mag = 0;
    m_err = 1'b0;
    if (rdy) begin
      if (m_q.size() == 0) m_fsign = s;
      m_q.push_back(p);
      if (m_q.size() == 2) begin
        complete = 1;
        for (int i = 0; i < 2; i++) mag += int'(m_q[i]) * (16 ** i);
        m_q.delete();
      end
    end else if (m_q.size() > 0) begin
      m_q.delete();
      m_err = 1'b1;
    end
    if (clr_overrun) m_over = 1'b0;
    if (complete) begin
      if (!m_valid || prod_ready) begin
        m_valid = 1'b1; m_data = 8'(mag); m_sign = m_fsign;
      end else begin
        m_over = 1'b1;
      end
    end else if (m_valid && prod_ready) begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{4'h5, 4'hA, 1'b0, 8'hA5, 1'b0, 9'h0A5};
    vecs[1] = '{4'hC, 4'h0, 1'b1, 8'h0C, 1'b1, 9'h1F4};
    vecs[2] = '{4'h0, 4'h0, 1'b1, 8'h00, 1'b1, 9'h000};
    vecs[3] = '{4'hF, 4'hF, 1'b1, 8'hFF, 1'b1, 9'h101};
    vecs[4] = '{4'h1, 4'h2, 1'b0, 8'h21, 1'b0, 9'h021};
    vecs[5] = '{4'h0, 4'h8, 1'b1, 8'h80, 1'b1, 9'h180};

    rst = 1'b1; p = '0; s = 1'b0; rdy = 1'b0; prod_ready = 1'b0; clr_overrun = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", prod_valid, 0);
    chk("reset_data", prod_data, 0);
    chk("reset_signed", prod_signed, 0);
    chk("reset_err", err_short, 0);
    chk("reset_overrun", overrun, 0);
    rst = 1'b0;
    step();

    // table-driven frames with an always-ready consumer
    prod_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      beat(vecs[i].c0, vecs[i].sg);
      chk("vec_not_yet_valid", prod_valid, 0);
      beat(vecs[i].c1, ~vecs[i].sg);
      idle();
      chk("vec_valid", prod_valid, 1);
      chk("vec_data", prod_data, vecs[i].exp_data);
      chk("vec_sign", prod_sign, vecs[i].exp_sign);
      chk("vec_signed", prod_signed, vecs[i].exp_signed);
      step();
      chk("vec_consumed", prod_valid, 0);
    end

    // short frame
    beat(4'h3, 1'b0);
    idle();
    step();
    chk("short_err_pulse", err_short, 1);
    chk("short_no_valid", prod_valid, 0);
    step();
    chk("short_err_one_cycle", err_short, 0);
    beat(4'h1, 1'b0); beat(4'h2, 1'b0); idle();
    chk("after_short_data", prod_data, 8'h21);
    chk("after_short_valid", prod_valid, 1);
    step();

    // backpressure and overrun with back-to-back frames
    prod_ready = 1'b0;
    beat(4'h1, 1'b0); beat(4'h1, 1'b0);
    beat(4'h2, 1'b0); beat(4'h2, 1'b0); idle();
    chk("bp_hold_data", prod_data, 8'h11);
    chk("bp_valid", prod_valid, 1);
    chk("bp_overrun", overrun, 1);
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
    chk("bp_overrun_cleared", overrun, 0);
    chk("bp_still_held", prod_data, 8'h11);
    prod_ready = 1'b1; step(); prod_ready = 1'b0;
    chk("bp_accepted", prod_valid, 0);

    // simultaneous accept and complete
    beat(4'h1, 1'b0); beat(4'h1, 1'b0); idle();
    chk("sim_held", prod_data, 8'h11);
    beat(4'h3, 1'b0);
    prod_ready = 1'b1;
    beat(4'h3, 1'b0); idle();
    chk("sim_data", prod_data, 8'h33);
    chk("sim_valid", prod_valid, 1);
    chk("sim_no_overrun", overrun, 0);
    prod_ready = 1'b0;

    // overrun set wins over a simultaneous clear
    beat(4'h4, 1'b0);
    clr_overrun = 1'b1;
    beat(4'h4, 1'b0); idle();
    clr_overrun = 1'b0;
    chk("set_wins_overrun", overrun, 1);
    chk("set_wins_data", prod_data, 8'h33);

    // asynchronous reset mid-frame while holding a result
    beat(4'h7, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", prod_valid, 0);
    chk("arst_data", prod_data, 0);
    chk("arst_overrun", overrun, 0);
    step();
    chk("arst_no_err", err_short, 0);
    idle();
    #3 rst = 1'b0;
    step();
    chk("arst_release_no_err", err_short, 0);
    beat(4'h7, 1'b0); beat(4'h8, 1'b0); idle();
    chk("arst_fresh_data", prod_data, 8'h87);
    chk("arst_fresh_valid", prod_valid, 1);

    // randomized run against the reference model
    rst = 1'b1; #2; rst = 1'b0;
    m_q.delete(); m_fsign = 0; m_valid = 0; m_data = 0; m_sign = 0; m_over = 0; m_err = 0;
    step();
    for (int c = 0; c < 400; c++) begin
      rdy         = ($urandom_range(0, 4) != 0);
      p           = 4'($urandom);
      s           = 1'($urandom);
      prod_ready  = ($urandom_range(0, 2) == 0);
      clr_overrun = ($urandom_range(0, 7) == 0);
      model_edge();
      step();
      chk("rand_valid", prod_valid, m_valid);
      chk("rand_err", err_short, m_err);
      chk("rand_overrun", overrun, m_over);
      if (m_valid) begin
        chk("rand_data", prod_data, m_data);
        chk("rand_signed", prod_signed, signed_of(m_sign, m_data));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_result_collector.md
Name: mul_result_collector

Overview:
- Receive-side partner of the multiplier output interface (p, s, rdy).
- The multiplier emits each product as BEATS consecutive P_WIDTH-bit chunks, least-significant chunk first, framed by rdy. This block reassembles the chunks into one full-width product, attaches the sign, and offers the result on a valid/ready handshake.
- Sits between the multiplier's io_out and the host/FPGA-side result consumer.

Parameters:
- P_WIDTH, 4, bits of product delivered per beat (matches multiplier p width).
- BEATS, 2, chunks per product; PRODUCT_WIDTH = P_WIDTH*BEATS.
- HAS_SIGN, 1, 1 = sample s on first beat; 0 = sign forced to 0.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- p  input  P_WIDTH  product chunk from multiplier.
- s  input  1  product sign from multiplier, valid on first beat only.
- rdy  input  1  chunk valid; high for exactly BEATS consecutive cycles per product.
- prod_data  output  PRODUCT_WIDTH  reassembled magnitude.
- prod_sign  output  1  captured sign.
- prod_signed  output  PRODUCT_WIDTH+1  two's-complement product: sign ? -{0,mag} : {0,mag}.
- prod_valid  output  1  result available.
- prod_ready  input  1  consumer accepts result.
- err_short  output  1  one-cycle pulse: frame aborted (rdy dropped early).
- overrun  output  1  sticky: completed frame dropped because output was full.
- clr_overrun  input  1  synchronous clear of overrun.

Behaviour:
- Reset (async, immediate): state IDLE, beat counter 0, shift register 0, prod_data 0, prod_sign 0, prod_signed 0, prod_valid 0, err_short 0, overrun 0.
- Collection FSM: IDLE, COLLECT.
  - IDLE and rdy=1: capture p into chunk 0, capture s if HAS_SIGN, count=1. Go to COLLECT, or complete immediately if BEATS=1.
  - COLLECT and rdy=1: place p at chunk[count], count++. When count reaches BEATS the frame is complete and the FSM returns to IDLE.
  - COLLECT and rdy=0: abort. Discard partial data, pulse err_short for 1 cycle, go to IDLE.
  - Back-to-back frames: a rdy=1 on the cycle after completion starts a new frame, with no idle cycle required.
- Output register is separate from the shift register, so collection continues while a result is held.
- Completion, last beat sampled at edge N:
  - Output empty, or prod_valid&prod_ready at edge N: load the output register; prod_valid=1 after edge N (latency 1 edge from last beat).
  - Output full and not consumed at edge N: new frame dropped, overrun set (sticky), held result unchanged.
- Handshake: prod_valid stays high and outputs stay stable until prod_valid&prod_ready. On acceptance with no simultaneous completion, prod_valid=0 after the edge.
- Arithmetic:
  - prod_signed is combinational from the output register.
  - Negation is modulo 2^(PRODUCT_WIDTH+1).
  - sign=1 with magnitude 0 yields 0 (no negative zero).
- clr_overrun: overrun=0 next edge. If an overrun event occurs on the same cycle, set wins.
- Reset mid-frame or while holding: everything is lost, no err_short pulse.
- p and s are ignored when rdy=0; s is ignored on non-first beats.

Test Plan:
- Basic: rdy=1 two cycles with p=0x5 then 0xA, s=0 on beat 0; prod_ready=1 -> prod_valid one edge after beat 2, prod_data=0xA5, prod_signed=9'h0A5, prod_sign=0.
- Signed: p=0xC,0x0, s=1 -> prod_data=0x0C, prod_signed=9'h1F4 (-12). Repeat with p=0x0,0x0, s=1 -> prod_signed=9'h000.
- Short frame: rdy=1 for one cycle (p=0x3), then 0 -> err_short pulses exactly 1 cycle, prod_valid stays 0. The next full frame 0x1,0x2 -> prod_data=0x21.
- Backpressure and overrun: prod_ready=0. Frame 0x11 then back-to-back frame 0x22 -> prod_data holds 0x11, overrun=1. Pulse clr_overrun -> overrun=0. Then prod_ready=1 -> 0x11 accepted, prod_valid drops.
- Simultaneous accept and complete: hold 0x11 with prod_ready=0. Raise prod_ready on the edge where frame 0x33 completes -> prod_data=0x33, prod_valid stays 1, overrun=0.
- Async reset mid-frame: rst asserted between beat 1 and beat 2 -> all outputs 0 immediately, no err_short. After release, a fresh frame 0x7,0x8 -> prod_data=0x87.
